// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and the memory device it drives:
// command encodings, RV32I load/store funct3 codes, fault causes and FSM states.
package lsu_pkg;

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_ILLEGAL  = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Stores only exist in B/H/W widths; loads additionally allow BU/HU.
    function automatic logic funct3_illegal(input logic [2:0] funct3, input logic store);
        return (funct3 == 3'd3) || (funct3[2:1] == 2'b11) || (store && funct3[2]);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response channel of the load/store unit.
// master = execute stage, slave = LSU.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_cause;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault, resp_cause
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault, resp_cause
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask, lane-shifted store data, extended load
// data and the illegal/misaligned classification of a request.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        store,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);
    logic [4:0]  shamt;
    logic [31:0] lane_bits;
    logic [31:0] shifted;

    assign shamt = {offset, 3'b000};

    always_comb begin
        case (funct3[1:0])
            2'd0:    mask = 4'b0001 << offset;
            2'd1:    mask = 4'b0011 << offset;
            default: mask = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bits[gi*8 +: 8] = {8{mask[gi]}};
        end
    endgenerate

    // mem ORs write data into the word, so bytes outside the mask must be zero.
    assign wdata_lane = (wdata << shamt) & lane_bits;
    assign shifted    = rdata >> shamt;

    assign illegal    = funct3_illegal(funct3, store);
    assign misaligned = ((funct3[1:0] == 2'd1) && offset[0]) ||
                        ((funct3[1:0] == 2'd2) && (offset != 2'd0));

    always_comb begin
        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata_ext = {24'd0, shifted[7:0]};
            F3_HU:   rdata_ext = {16'd0, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE/ACCESS/RESP FSM, request latch, response registers and
// the read timeout counter in front of the memory device.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    lsu_if.slave        core,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic        mem_enable,
    output logic        mem_cmd,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e      state_reg;
    logic        store_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  offset_reg;
    logic [7:0]  wait_cnt_reg;
    logic        mem_enable_reg;
    logic        mem_cmd_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_mask_reg;
    logic        resp_valid_reg;
    logic        resp_fault_reg;
    cause_e      resp_cause_reg;
    logic [31:0] resp_rdata_reg;

    logic        in_idle;
    logic        cur_store;
    logic [2:0]  cur_funct3;
    logic [1:0]  cur_offset;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        misaligned;
    logic        illegal;

    // One aligner serves both phases: the live request while IDLE, the latch afterwards.
    assign in_idle    = (state_reg == ST_IDLE);
    assign cur_store  = in_idle ? core.req_store       : store_reg;
    assign cur_funct3 = in_idle ? core.req_funct3      : funct3_reg;
    assign cur_offset = in_idle ? core.req_addr[1:0]   : offset_reg;

    lsu_align u_align (
        .funct3     (cur_funct3),
        .store      (cur_store),
        .offset     (cur_offset),
        .wdata      (core.req_wdata),
        .rdata      (mem_rdata),
        .mask       (lane_mask),
        .wdata_lane (lane_wdata),
        .rdata_ext  (load_data),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            store_reg      <= 1'b0;
            funct3_reg     <= 3'd0;
            offset_reg     <= 2'd0;
            wait_cnt_reg   <= 8'd0;
            mem_enable_reg <= 1'b0;
            mem_cmd_reg    <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
            mem_mask_reg   <= 4'd0;
            resp_valid_reg <= 1'b0;
            resp_fault_reg <= 1'b0;
            resp_cause_reg <= CAUSE_NONE;
            resp_rdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (core.req_valid) begin
                        store_reg    <= core.req_store;
                        funct3_reg   <= core.req_funct3;
                        offset_reg   <= core.req_addr[1:0];
                        wait_cnt_reg <= 8'd0;
                        if (illegal || misaligned) begin
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_fault_reg <= 1'b1;
                            resp_cause_reg <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                            resp_rdata_reg <= 32'd0;
                        end else begin
                            state_reg      <= ST_ACCESS;
                            mem_enable_reg <= 1'b1;
                            mem_cmd_reg    <= core.req_store ? MEM_CMD_WRITE : MEM_CMD_READ;
                            mem_addr_reg   <= {core.req_addr[31:2], 2'b00};
                            mem_mask_reg   <= lane_mask;
                            mem_wdata_reg  <= core.req_store ? lane_wdata : 32'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (store_reg || mem_valid || (wait_cnt_reg == TIMEOUT_CNT)) begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                        mem_enable_reg <= 1'b0;
                        mem_cmd_reg    <= 1'b0;
                        mem_addr_reg   <= 32'd0;
                        mem_wdata_reg  <= 32'd0;
                        mem_mask_reg   <= 4'd0;
                        if (store_reg || mem_valid) begin
                            resp_fault_reg <= 1'b0;
                            resp_cause_reg <= CAUSE_NONE;
                            resp_rdata_reg <= store_reg ? 32'd0 : load_data;
                        end else begin
                            resp_fault_reg <= 1'b1;
                            resp_cause_reg <= CAUSE_TIMEOUT;
                            resp_rdata_reg <= 32'd0;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (core.resp_ready) begin
                        state_reg      <= ST_IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_fault_reg <= 1'b0;
                        resp_cause_reg <= CAUSE_NONE;
                        resp_rdata_reg <= 32'd0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Gating with reset keeps a store in flight from writing on the reset edge.
    assign core.req_ready  = reset && in_idle;
    assign core.resp_valid = resp_valid_reg;
    assign core.resp_fault = resp_fault_reg;
    assign core.resp_cause = resp_cause_reg;
    assign core.resp_rdata = resp_rdata_reg;
    assign mem_enable      = reset && mem_enable_reg;
    assign mem_cmd         = reset && mem_cmd_reg;
    assign mem_addr        = reset ? mem_addr_reg  : 32'd0;
    assign mem_mask        = reset ? mem_mask_reg  : 4'd0;
    assign mem_wdata       = reset ? mem_wdata_reg : 32'd0;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, random transactions against a
// behavioural model, plus back-pressure and mid-store reset sequences.
`timescale 1ns/1ps
module tb_lsu;
    import lsu_pkg::*;

    localparam int TMO = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lsu_if core ();
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic        mem_enable, mem_cmd, mem_valid;

    lsu #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .core       (core),
        .mem_addr   (mem_addr),
        .mem_mask   (mem_mask),
        .mem_enable (mem_enable),
        .mem_cmd    (mem_cmd),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid)
    );

    // Memory device: combinational read, OR-in write, valid after a programmable delay.
    logic [31:0] mem_words [0:63] = '{default: 32'd0};
    logic [31:0] ref_words [0:63] = '{default: 32'd0};
    int          valid_delay = 0;
    int          en_cnt = 0;
    int          write_count = 0;
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'd0;

    assign mem_rdata = mem_words[mem_addr[7:2]];
    assign mem_valid = mem_enable && (en_cnt >= valid_delay);

    always @(posedge clk) begin
        if (mem_enable) en_cnt <= en_cnt + 1;
        else            en_cnt <= 0;
        if (pre_we) begin
            mem_words[pre_idx] <= pre_val;
        end else if (mem_enable && mem_cmd == MEM_CMD_WRITE) begin
            mem_words[mem_addr[7:2]] <= mem_words[mem_addr[7:2]] | mem_wdata;
            write_count <= write_count + 1;
        end
    end

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] rdata;
        logic [3:0]  mask;
        logic [31:0] lane;
        int          lat;
        int          en;
    } exp_t;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          dly;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference built from the width/sign rules with plain arithmetic.
    function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] word, input int dly);
        exp_t e;
        int size, off;
        bit sgn;
        logic [31:0] keep, v;
        off = int'(addr[1:0]);
        sgn = 1'b0;
        case (f3)
            3'd0:    begin size = 1; sgn = 1'b1; end
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    size = 4;
            3'd4:    size = 1;
            3'd5:    size = 2;
            default: size = 0;
        endcase
        keep   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        e.mask = 4'(((1 << size) - 1) << off);
        e.lane = (wd & keep) << (8 * off);
        e.rdata = 32'd0;
        if (size == 0 || (st && f3 > 3'd2)) begin
            e.cause = 2'd2; e.lat = 1; e.en = 0;
        end else if (off % size != 0) begin
            e.cause = 2'd1; e.lat = 1; e.en = 0;
        end else if (st) begin
            e.cause = 2'd0; e.lat = 2; e.en = 1;
        end else if (dly > TMO) begin
            e.cause = 2'd3; e.lat = TMO + 2; e.en = TMO + 1;
        end else begin
            v = (word >> (8 * off)) & keep;
            if (sgn && v[8 * size - 1]) v = v | ~keep;
            e.cause = 2'd0; e.rdata = v; e.lat = 2 + dly; e.en = 1 + dly;
        end
        return e;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = 6'(idx); pre_val = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_words[idx] = val;
    endtask

    // Issue one request, observe the memory port and response, then hand-shake.
    task automatic run_vec(input string tag, input vec_t v, input int stall);
        int lat, en;
        logic [1:0] cause;
        logic fault;
        logic [31:0] rdata, lane, maddr;
        logic [3:0] mask;
        logic cmd;
        lat = -1; en = 0; cause = 2'd0; fault = 1'b0; rdata = 32'd0;
        lane = 32'd0; maddr = 32'd0; mask = 4'd0; cmd = 1'b0;
        @(negedge clk);
        valid_delay = v.dly;
        check({tag, "_ready"}, 32'(core.req_ready), 32'd1);
        core.req_valid = 1'b1; core.req_store = v.st; core.req_funct3 = v.f3;
        core.req_addr = v.addr; core.req_wdata = v.wd;
        @(posedge clk); #1;
        core.req_valid = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (mem_enable) begin
                en++; mask = mem_mask; lane = mem_wdata; maddr = mem_addr; cmd = mem_cmd;
            end
            if (core.resp_valid) begin
                lat = k; cause = core.resp_cause; fault = core.resp_fault; rdata = core.resp_rdata;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(v.e.lat));
        check({tag, "_cause"}, 32'(cause), 32'(v.e.cause));
        check({tag, "_fault"}, 32'(fault), 32'(v.e.cause != 2'd0));
        check({tag, "_rdata"}, rdata, v.e.rdata);
        check({tag, "_en_cycles"}, 32'(en), 32'(v.e.en));
        if (v.e.en > 0) begin
            check({tag, "_mask"}, 32'(mask), 32'(v.e.mask));
            check({tag, "_maddr"}, maddr, {v.addr[31:2], 2'b00});
            check({tag, "_cmd"}, 32'(cmd), 32'(v.st));
            if (v.st) check({tag, "_wdata"}, lane, v.e.lane);
        end
        for (int s = 0; s < stall; s++) begin
            core.req_valid = 1'b1;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(core.resp_valid), 32'd1);
            check({tag, "_hold_rdata"}, core.resp_rdata, rdata);
            check({tag, "_hold_cause"}, 32'(core.resp_cause), 32'(cause));
            check({tag, "_hold_req_ready"}, 32'(core.req_ready), 32'd0);
            check({tag, "_hold_mem_en"}, 32'(mem_enable), 32'd0);
        end
        core.resp_ready = 1'b1;
        @(posedge clk); #1;
        core.resp_ready = 1'b0;
        core.req_valid = 1'b0;
        if (v.st && v.e.cause == 2'd0) ref_words[v.addr[7:2]] = ref_words[v.addr[7:2]] | v.e.lane;
        $display("txn %s st=%0d f3=%0d addr=%h wd=%h lat=%0d cause=%0d rdata=%h",
                 tag, v.st, v.f3, v.addr, v.wd, lat, cause, rdata);
    endtask

    vec_t vecs [0:21];

    initial begin
        int wc;
        vec_t rv;
        core.req_valid = 1'b0; core.req_store = 1'b0; core.req_funct3 = 3'd0;
        core.req_addr = 32'd0; core.req_wdata = 32'd0; core.resp_ready = 1'b0;

        // st f3 addr wdata dly | cause rdata mask lane lat en
        vecs[0]  = '{1'b0, 3'd0, 32'h41, 32'h0,        0,  '{2'd0, 32'hFFFFFFAA, 4'b0010, 32'h0, 2, 1}};
        vecs[1]  = '{1'b0, 3'd5, 32'h42, 32'h0,        0,  '{2'd0, 32'h00008899, 4'b1100, 32'h0, 2, 1}};
        vecs[2]  = '{1'b1, 3'd1, 32'h46, 32'h1234ABCD, 0,  '{2'd0, 32'h0, 4'b1100, 32'hABCD0000, 2, 1}};
        vecs[3]  = '{1'b0, 3'd2, 32'h44, 32'h0,        0,  '{2'd0, 32'hABCD0011, 4'b1111, 32'h0, 2, 1}};
        vecs[4]  = '{1'b0, 3'd2, 32'h42, 32'h0,        0,  '{2'd1, 32'h0, 4'b0000, 32'h0, 1, 0}};
        vecs[5]  = '{1'b0, 3'd3, 32'h40, 32'h0,        0,  '{2'd2, 32'h0, 4'b0000, 32'h0, 1, 0}};
        vecs[6]  = '{1'b1, 3'd4, 32'h40, 32'hFFFFFFFF, 0,  '{2'd2, 32'h0, 4'b0000, 32'h0, 1, 0}};
        vecs[7]  = '{1'b0, 3'd0, 32'h43, 32'h0,        0,  '{2'd0, 32'hFFFFFF88, 4'b1000, 32'h0, 2, 1}};
        vecs[8]  = '{1'b0, 3'd4, 32'h40, 32'h0,        0,  '{2'd0, 32'h000000BB, 4'b0001, 32'h0, 2, 1}};
        vecs[9]  = '{1'b0, 3'd1, 32'h40, 32'h0,        0,  '{2'd0, 32'hFFFFAABB, 4'b0011, 32'h0, 2, 1}};
        vecs[10] = '{1'b0, 3'd2, 32'h40, 32'h0,        0,  '{2'd0, 32'h8899AABB, 4'b1111, 32'h0, 2, 1}};
        vecs[11] = '{1'b0, 3'd6, 32'h40, 32'h0,        0,  '{2'd2, 32'h0, 4'b0000, 32'h0, 1, 0}};
        vecs[12] = '{1'b1, 3'd0, 32'h45, 32'hDEADBEFF, 0,  '{2'd0, 32'h0, 4'b0010, 32'h0000FF00, 2, 1}};
        vecs[13] = '{1'b1, 3'd1, 32'h45, 32'hFFFFFFFF, 0,  '{2'd1, 32'h0, 4'b0000, 32'h0, 1, 0}};
        vecs[14] = '{1'b0, 3'd2, 32'h44, 32'h0,        0,  '{2'd0, 32'hABCDFF11, 4'b1111, 32'h0, 2, 1}};
        vecs[15] = '{1'b0, 3'd1, 32'h4A, 32'h0,        16, '{2'd3, 32'h0, 4'b1100, 32'h0, 17, 16}};
        vecs[16] = '{1'b0, 3'd0, 32'h41, 32'h0,        15, '{2'd0, 32'hFFFFFFAA, 4'b0010, 32'h0, 17, 16}};
        vecs[17] = '{1'b0, 3'd4, 32'h42, 32'h0,        3,  '{2'd0, 32'h00000099, 4'b0100, 32'h0, 5, 4}};
        vecs[18] = '{1'b1, 3'd2, 32'h4C, 32'hCAFEF00D, 0,  '{2'd0, 32'h0, 4'b1111, 32'hCAFEF00D, 2, 1}};
        vecs[19] = '{1'b0, 3'd1, 32'h4E, 32'h0,        0,  '{2'd0, 32'hFFFFCAFE, 4'b1100, 32'h0, 2, 1}};
        vecs[20] = '{1'b1, 3'd0, 32'h4C, 32'h00000010, 20, '{2'd0, 32'h0, 4'b0001, 32'h00000010, 2, 1}};
        vecs[21] = '{1'b0, 3'd4, 32'h4C, 32'h0,        0,  '{2'd0, 32'h0000001D, 4'b0001, 32'h0, 2, 1}};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(core.req_ready), 32'd0);
        check("rst_resp_valid", 32'(core.resp_valid), 32'd0);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_resp_rdata", core.resp_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(core.req_ready), 32'd1);
        check("idle_mem_mask", 32'(mem_mask), 32'd0);

        preload(16, 32'h8899AABB);
        preload(17, 32'h00000011);

        for (int i = 0; i < 22; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

        // Back-pressure: response held for 5 cycles while a new request waits.
        rv = '{1'b0, 3'd0, 32'h41, 32'h0, 0, '{2'd0, 32'hFFFFFFAA, 4'b0010, 32'h0, 2, 1}};
        run_vec("stall", rv, 5);

        // Reset during the ACCESS cycle of a store: no write, outputs cleared.
        @(negedge clk);
        valid_delay = 0;
        wc = write_count;
        core.req_valid = 1'b1; core.req_store = 1'b1; core.req_funct3 = 3'd2;
        core.req_addr = 32'h50; core.req_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        core.req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rreset_req_ready", 32'(core.req_ready), 32'd0);
        check("rreset_resp_valid", 32'(core.resp_valid), 32'd0);
        check("rreset_mem_enable", 32'(mem_enable), 32'd0);
        check("rreset_mem_mask", 32'(mem_mask), 32'd0);
        check("rreset_mem_wdata", mem_wdata, 32'd0);
        check("rreset_resp_fault", 32'(core.resp_fault), 32'd0);
        check("rreset_writes", 32'(write_count), 32'(wc));
        reset = 1'b1;
        rv = '{1'b0, 3'd2, 32'h50, 32'h0, 0, '{2'd0, 32'h0, 4'b1111, 32'h0, 2, 1}};
        run_vec("rreset_lw", rv, 0);

        // Random transactions against the model.
        for (int i = 0; i < 150; i++) begin
            rv.st   = ($urandom_range(0, 9) < 3);
            rv.f3   = 3'($urandom_range(0, 7));
            rv.addr = 32'($urandom_range(0, 255));
            rv.wd   = $urandom;
            rv.dly  = ($urandom_range(0, 15) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
            rv.e    = model(rv.st, rv.f3, rv.addr, rv.wd, ref_words[rv.addr[7:2]], rv.dly);
            run_vec($sformatf("rnd%0d", i), rv, $urandom_range(0, 2));
        end

        for (int i = 0; i < 64; i++) check($sformatf("final_word%0d", i), mem_words[i], ref_words[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's execute stage and the simulated memory device (`mem`). It takes one byte/half/word load or store request per transaction and drives `mem`'s addr/mask/enable/cmd/write_data port. Store data is lane-aligned with unmasked lanes zeroed, because `mem` ORs write data into the word. Load data is extracted, sign- or zero-extended, and returned through a valid/ready response port with fault reporting.

## Interface
- `TIMEOUT`, 15: cycles a read may wait in ACCESS for `mem_valid` before faulting (1..255).
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU accepts request (IDLE only).
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU (loads); 0/1/2 (stores).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes response.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  transaction faulted.
- `resp_cause`  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout.
- `mem_addr`  out  32  to `mem.addr`, low two bits forced 0.
- `mem_mask`  out  4  byte-lane mask.
- `mem_enable`  out  1  access strobe.
- `mem_cmd`  out  1  `MEM_CMD_READ` / `MEM_CMD_WRITE`.
- `mem_wdata`  out  32  lane-shifted store data, zero outside mask.
- `mem_rdata`  in  32  from `mem.load_data`.
- `mem_valid`  in  1  from `mem.valid`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch the request.
  - Illegal funct3 → RESP, cause 2. Illegal means 3, 6 or 7 for any request, and 4/5 for stores.
  - Misaligned → RESP, cause 1. Misaligned means H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - Otherwise → ACCESS.
- ACCESS:
  - Drives `mem_enable`=1, `mem_addr` = {addr[31:2], 2'b00}, `mem_mask`, `mem_cmd`, `mem_wdata`.
  - Mask values: B = 4'b0001 << addr[1:0]; H = 4'b0011 << addr[1:0]; W = 4'b1111.
  - `mem_wdata` = `req_wdata` shifted left by 8·addr[1:0], ANDed with the expanded mask.
  - Store: exactly one ACCESS cycle, then RESP, cause 0. `mem_valid` is ignored.
  - Load with `mem_valid`=1: capture `mem_rdata` >> 8·addr[1:0], then extend. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through. Go to RESP.
  - Load without `mem_valid`: increment the wait counter. When the counter reaches `TIMEOUT`, go to RESP with cause 3 and rdata 0.
- RESP:
  - `resp_valid`=1; response fields are stable until `resp_ready`.
  - On `resp_ready` → IDLE.
- Whenever not in ACCESS, all `mem_*` outputs are 0.
- Reset values: all outputs 0 (`req_ready` 0 during reset), state IDLE, counter 0.
- Reset mid-transaction drops any pending request or response. No memory write occurs after the reset edge.

## Timing
- Accept at edge N.
- Fault-free load with a combinational `mem`: ACCESS in cycle N+1, `resp_valid` in cycle N+2.
- Store: `mem_enable` high for exactly one cycle (N+1); `resp_valid` in N+2.
- Pre-access fault (cause 1 or 2): `resp_valid` in N+1, `mem_enable` never asserted.
- Timeout: `resp_valid` TIMEOUT+1 cycles after ACCESS entry.
- A response handshake and a new request cannot complete in the same cycle. The next request is accepted no earlier than the cycle after the handshake. Peak rate is one transaction per 3 cycles.
- `resp_valid` held with `resp_ready`=0: all `resp_*` outputs are held indefinitely and `mem_enable` stays 0.

## Structure
- `MEM_CMD_READ`, `MEM_CMD_WRITE`, funct3 codes and cause codes live in the shared defines header used by `mem`. The LSU must not redefine them locally.
- One combinational sub-module, `lsu_align`, takes size, offset, store data and raw load data. It returns mask, shifted write data, extended load data and the misaligned/illegal flags.
- The top level holds the FSM, the request latch, the response registers and the timeout counter.

## Test plan
- Word 0x40 = 0x8899AABB; LB addr 0x41 → `mem_mask` 4'b0010, `resp_rdata` 0xFFFFFFAA, cause 0, `resp_valid` two cycles after accept.
- Word 0x40 = 0x8899AABB; LHU addr 0x42 → `mem_mask` 4'b1100, `resp_rdata` 0x00008899.
- SH addr 0x46, wdata 0x1234ABCD → one-cycle `mem_enable`, `mem_mask` 4'b1100, `mem_wdata` 0xABCD0000. Word previously 0x00000011 reads back 0xABCD0011 via LW 0x44.
- LW addr 0x42 → cause 1 in N+1, no `mem_enable`. funct3=3 → cause 2. Store with funct3=4 → cause 2.
- Load with `mem_valid` tied 0, TIMEOUT=15 → `resp_valid` exactly 16 cycles after ACCESS entry, cause 3, rdata 0.
- `resp_ready` held low 5 cycles with `req_valid` high → `req_ready` stays 0 and response is stable. Separately, assert `reset` low during ACCESS of a store → no write; outputs 0 next cycle.
